// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : MIPS instruction-fetch stage. Owns the PC, issues single-
//               outstanding word reads and feeds instruction/newPC to IF/ID.
//               Optional redirect-alignment check: define IF_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] newPC,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign_err
);

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold;
    logic [31:0] r_instr;
    logic [31:0] r_newpc;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_target_al;
    logic [31:0] w_pc_inc;

    assign w_redirect  = branch_taken | jump;
    assign w_target    = branch_taken ? branch_target : jump_target;
    assign w_target_al = w_target & c_word_mask;
    assign w_pc_inc    = r_pc + c_pc_step;

    assign flush       = w_redirect & ~rst;
    assign instruction = r_instr;
    assign newPC       = r_newpc;
    assign if_valid    = r_if_valid;

    // A request already presented in FETCH is kept up through a redirect; only
    // the chained request issued alongside a delivered word is suppressed.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        if (!rst) begin
            case (r_state)
                S_FETCH: imem_req = 1'b1;
                S_WAIT: begin
                    if (imem_valid && pc_en && !w_redirect) begin
                        imem_req  = 1'b1;
                        imem_addr = w_pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_hold     <= '0;
            r_instr    <= '0;
            r_newpc    <= '0;
            r_if_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= w_target_al;
            r_if_valid <= 1'b0;
            // The in-flight response, if any, must be swallowed before refetching.
            case (r_state)
                S_FETCH: r_state <= imem_ready ? S_DROP : S_FETCH;
                S_WAIT:  r_state <= imem_valid ? S_FETCH : S_DROP;
                S_DROP:  r_state <= imem_valid ? S_FETCH : S_DROP;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            if (pc_en) begin
                r_if_valid <= 1'b0;
            end
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        r_pc <= w_pc_inc;
                        if (pc_en) begin
                            r_instr    <= imem_rdata;
                            r_newpc    <= w_pc_inc;
                            r_if_valid <= 1'b1;
                            r_state    <= imem_ready ? S_WAIT : S_FETCH;
                        end else begin
                            r_hold  <= imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (pc_en) begin
                        r_instr    <= r_hold;
                        r_newpc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_valid) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

`ifdef IF_ALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_redirect && (w_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch with a latency-programmable
//               instruction memory model and an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
`ifdef IF_ALIGN_CHK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] newPC;
    logic        if_valid;
    logic        flush;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb_q[$];
    logic        sb_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;

    logic        m_busy;
    logic [31:0] m_addr;
    int          m_cnt;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_en        (pc_en),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .newPC        (newPC),
        .if_valid     (if_valid),
        .flush        (flush),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: response appears mem_lat cycles after the accepting edge.
    always @(posedge clk) begin
        if (rst) begin
            m_busy     <= 1'b0;
            m_addr     <= '0;
            m_cnt      <= 0;
            imem_valid <= 1'b0;
            imem_rdata <= '0;
        end else begin
            imem_valid <= 1'b0;
            if (m_busy) begin
                if (m_cnt <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(m_addr);
                    m_busy     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req && imem_ready) begin
                if (mem_lat <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(imem_addr);
                end else begin
                    m_busy <= 1'b1;
                    m_addr <= imem_addr;
                    m_cnt  <= mem_lat - 1;
                end
            end
        end
    end

    // Scoreboard: every word IF/ID captures must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && sb_en && pc_en && if_valid && !flush && sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (instruction !== e.instr || newPC !== e.npc) begin
                bad++;
                $display("FAIL sb_out: got instr=%h newPC=%h want instr=%h newPC=%h",
                         instruction, newPC, e.instr, e.npc);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.instr = mem_word(a);
        e.npc   = a + 32'd4;
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input int lat);
        rst          = 1'b1;
        pc_en        = 1'b1;
        branch_taken = 1'b0;
        jump         = 1'b0;
        imem_ready   = 1'b1;
        mem_lat      = lat;
        sb_q.delete();
        sb_en        = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) step;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending want 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; pc_en = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        imem_ready = 1'b1; mem_lat = 1; sb_q.delete(); sb_en = 1'b1;
        push_exp(32'h0040_0000);
        push_exp(32'h0040_0004);
        push_exp(32'h0040_0008);
        step; step;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_req: got %b want 0", imem_req);
        end
        total++;
        if ({instruction, newPC} !== 64'd0) begin
            bad++; $display("FAIL rst_data: got %h/%h want 0/0", instruction, newPC);
        end
        total++;
        if ({if_valid, flush, misalign_err} !== 3'b000) begin
            bad++; $display("FAIL rst_flags: got %b want 000", {if_valid, flush, misalign_err});
        end
        step; rst = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
            bad++; $display("FAIL addr0: got %b/%h want 1/00400000", imem_req, imem_addr);
        end
        step; @(negedge clk);
        total++;
        if (imem_addr !== 32'h0040_0004 || if_valid !== 1'b0) begin
            bad++; $display("FAIL addr1: got %h v=%b want 00400004 v=0", imem_addr, if_valid);
        end
        step; @(negedge clk);
        total++;
        if (imem_addr !== 32'h0040_0008 || if_valid !== 1'b1 || newPC !== 32'h0040_0004) begin
            bad++; $display("FAIL addr2: got %h v=%b npc=%h want 00400008 v=1 npc=00400004",
                            imem_addr, if_valid, newPC);
        end
        wait_drain("stream");
    endtask

    task automatic test_stall;
        do_reset(1);
        push_exp(32'h0040_0000);
        push_exp(32'h0040_0004);
        push_exp(32'h0040_0008);
        step;
        step; pc_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step; @(negedge clk);
            total++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || newPC !== 32'h0040_0004 ||
                instruction !== mem_word(32'h0040_0000)) begin
                bad++; $display("FAIL stall_frozen: got req=%b v=%b npc=%h ins=%h want 0/1/00400004/%h",
                                imem_req, if_valid, newPC, instruction, mem_word(32'h0040_0000));
            end
        end
        step; pc_en = 1'b1;
        step; @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin
            bad++; $display("FAIL stall_next: got %b/%h want 1/00400008", imem_req, imem_addr);
        end
        wait_drain("stall");
    endtask

    task automatic test_redirect_drop;
        do_reset(3);
        push_exp(32'h0040_0100);
        step; branch_taken = 1'b1; branch_target = 32'h0040_0100;
        @(negedge clk);
        total++;
        if (flush !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL drop_flush: got flush=%b req=%b want 1/0", flush, imem_req);
        end
        step; branch_taken = 1'b0;
        @(negedge clk);
        total++;
        if (flush !== 1'b0 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL drop_after: got flush=%b v=%b req=%b want 0/0/0", flush, if_valid, imem_req);
        end
        for (int i = 0; i < 10; i++) begin
            step; @(negedge clk);
            if (imem_req === 1'b1) break;
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
            bad++; $display("FAIL drop_refetch: got %b/%h want 1/00400100", imem_req, imem_addr);
        end
        wait_drain("drop");
    endtask

    task automatic test_priority;
        do_reset(1);
        push_exp(32'h0040_0200);
        step;
        step;
        branch_taken = 1'b1; branch_target = 32'h0040_0200;
        jump = 1'b1; jump_target = 32'h0050_0000;
        @(negedge clk);
        total++;
        if (flush !== 1'b1) begin
            bad++; $display("FAIL prio_flush: got %b want 1", flush);
        end
        step; branch_taken = 1'b0; jump = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200 || if_valid !== 1'b0) begin
            bad++; $display("FAIL prio_addr: got %b/%h v=%b want 1/00400200 v=0", imem_req, imem_addr, if_valid);
        end
        wait_drain("prio");
    endtask

    task automatic test_wrap;
        do_reset(1);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        step;
        step; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step; jump = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", imem_req, imem_addr);
        end
        step; @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_zero: got %b/%h want 1/00000000", imem_req, imem_addr);
        end
        wait_drain("wrap");
    endtask

    task automatic test_ready_rst;
        do_reset(1);
        sb_en = 1'b0;
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                bad++; $display("FAIL ready_hold: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC);
            end
            step;
        end
        imem_ready = 1'b1;
        step;
        step; mem_lat = 3;
        step; @(negedge clk);
        total++;
        if (if_valid !== 1'b1 || newPC !== 32'h0040_0008) begin
            bad++; $display("FAIL pre_rst: got v=%b npc=%h want 1/00400008", if_valid, newPC);
        end
        step; rst = 1'b1;
        step; rst = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++; $display("FAIL rst_refetch: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
        total++;
        if ({instruction, newPC} !== 64'd0 || if_valid !== 1'b0) begin
            bad++; $display("FAIL rst_outs: got %h/%h v=%b want 0/0 v=0", instruction, newPC, if_valid);
        end
    endtask

    task automatic test_misalign;
        do_reset(1);
        push_exp(32'h0040_0100);
        step;
        step; branch_taken = 1'b1; branch_target = 32'h0040_0102;
        step; branch_taken = 1'b0;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
            bad++; $display("FAIL mis_addr: got %b/%h want 1/00400100", imem_req, imem_addr);
        end
        total++;
        if (misalign_err !== EXP_MIS) begin
            bad++; $display("FAIL mis_flag: got %b want %b", misalign_err, EXP_MIS);
        end
        step; step; @(negedge clk);
        total++;
        if (misalign_err !== EXP_MIS) begin
            bad++; $display("FAIL mis_sticky: got %b want %b", misalign_err, EXP_MIS);
        end
        wait_drain("mis");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_stall;
        test_redirect_drop;
        test_priority;
        test_wrap;
        test_ready_rst;
        test_misalign;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipelined MIPS core. Owns the program counter, issues word reads to instruction memory over a single-outstanding request/response handshake, and presents the fetched `instruction` and `newPC` (PC+4) to the IF/ID pipeline register. Honours the hazard unit's stall (`pc_en`) and the ID-stage branch/jump redirect, discarding in-flight fetches on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `pc_en` in 1: 1 = downstream IF/ID captures outputs this cycle; 0 = stall.
- `branch_taken` in 1: redirect to `branch_target`.
- `branch_target` in 32: branch destination.
- `jump` in 1: redirect to `jump_target`.
- `jump_target` in 32: jump destination.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: word-aligned read address.
- `imem_ready` in 1: memory accepts request this cycle.
- `imem_valid` in 1: read data returned this cycle.
- `imem_rdata` in 32: read data.
- `instruction` out 32: fetched word to IF/ID.
- `newPC` out 32: fetch address + 4 to IF/ID.
- `if_valid` out 1: `instruction`/`newPC` hold a real fetch (0 = bubble).
- `flush` out 1: one-cycle pulse; IF/ID must load a bubble.
- `misalign_err` out 1: sticky redirect-misalignment flag (see Configuration).

## Operation
- `pc`: address of next/outstanding request. States: FETCH, WAIT, HOLD, DROP.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. Accepted (`imem_ready`) -> WAIT, else stay, address held.
- WAIT, `imem_valid` and `pc_en`: `instruction`<=`imem_rdata`, `newPC`<=`pc`+4, `if_valid`<=1, `pc`<=`pc`+4; same cycle `imem_req`=1, `imem_addr`=`pc`+4; accepted -> WAIT, else FETCH.
- WAIT, `imem_valid` and not `pc_en`: data into internal hold register, `pc`<=`pc`+4 -> HOLD; outputs unchanged.
- WAIT, no `imem_valid`: stay.
- HOLD: `imem_req`=0. On `pc_en`: hold register -> `instruction`, `newPC`<=`pc`, `if_valid`<=1 -> FETCH.
- Redirect (`branch_taken` or `jump`; `branch_taken` wins if both): any state, priority over `pc_en`. `pc`<=target with [1:0] forced 0; `if_valid`<=0; `flush`=1 that cycle; hold register discarded. No new request that cycle. Next state DROP if a request is outstanding and its `imem_valid` is not in this cycle (WAIT without response, or FETCH accepted this cycle), else FETCH.
- DROP: `imem_req`=0; next `imem_valid` discarded -> FETCH. Redirect in DROP updates `pc` only, stays DROP.
- `imem_valid` in FETCH or HOLD is ignored.
- Arithmetic: `pc`+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state FETCH, `instruction`=0, `newPC`=0, `if_valid`=0, `flush`=0, `misalign_err`=0. `imem_req` gated low while `rst`=1.
- `rst` mid-operation abandons any outstanding request; instruction memory shares `rst` and drops it too.
- `imem_req`/`imem_addr` combinational from state, `pc`, `imem_valid`, `pc_en`, `imem_ready`, redirect. All other outputs registered.
- Latency: zero-wait memory (`imem_ready`=1, `imem_valid` next cycle), request in cycle 0 -> `if_valid` in cycle 2. Throughput 1 instruction/cycle.
- `flush` is combinational from redirect, same cycle.

## Configuration
- `IF_ALIGN_CHK_EN` defined: redirect target with [1:0]!=0 sets `misalign_err` (sticky until `rst`); fetch still proceeds at target with [1:0] cleared.
- Undefined: [1:0] cleared silently; `misalign_err` tied 0.

## Test plan
- `RESET_PC`=0x0040_0000, zero-wait memory, `pc_en`=1 -> `imem_addr` 0x400000, 0x400004, 0x400008 on consecutive cycles; first `if_valid`=1 two cycles after reset release with `newPC`=0x400004.
- `pc_en`=0 for 3 cycles while a response arrives -> outputs frozen, `imem_req`=0 in HOLD; on release held word presented, next request 0x400008.
- Response delayed 2 cycles, `branch_taken`=1 with target 0x400100 while in WAIT -> `flush`=1 one cycle, `if_valid`=0, stale response dropped, next request 0x400100.
- `branch_taken`=1 (0x400200) and `jump`=1 (0x500000) in the same cycle -> next request 0x400200.
- `imem_ready`=0 for 4 cycles in FETCH -> `imem_req`=1, `imem_addr` stable; `rst` pulse mid-WAIT -> next request `RESET_PC`, outputs zero.
- Redirect to 0x400102: with `IF_ALIGN_CHK_EN`, `misalign_err`=1 and stays 1, fetch 0x400100; without it, `misalign_err`=0, fetch 0x400100.
